// File: rtl/sweep_pkg.sv
// Shared types for the triangle sweep controller.
package sweep_pkg;
  typedef enum logic [2:0] {
    IDLE,
    UP,
    HOLD,
    DOWN,
    DONE
  } sweep_state_t;
endpackage

// File: rtl/sweep_hold_timer.sv
// Dwell timer for the sweep peak: counts 0..HOLD_CYCLES-1 while enabled and
// flags the final value so the controller can leave the dwell.
module sweep_hold_timer #(
  parameter int HOLD_W      = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);
  localparam logic [HOLD_W-1:0] LAST_VAL = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [HOLD_W-1:0] ONE      = HOLD_W'(1);

  logic [HOLD_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + ONE;
  end

  assign last = (cnt == LAST_VAL);
endmodule

// File: rtl/sweep_sequencer.sv
// Triangle sweep controller: 0 -> limit, dwell, limit -> 0, then a done pulse.
// Build option SWEEP_PAUSE_EN adds a pause input that freezes an active sweep.
//
//   state | meaning
//   IDLE  | waiting for start handshake, count 0
//   UP    | count rising toward limit_q
//   HOLD  | count frozen at limit_q while the dwell timer runs
//   DOWN  | count falling toward 0 (DONE entered from count 0)
//   DONE  | one-cycle done pulse, then back to IDLE
module sweep_sequencer
  import sweep_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int HOLD_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] limit,
  input  logic             abort,
`ifdef SWEEP_PAUSE_EN
  input  logic             pause,
`endif
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             busy,
  output logic             done
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  sweep_state_t     state, state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] limit_q, limit_nxt;
  logic [WIDTH-1:0] count_inc;
  logic             hold_last;
  logic             stall;

`ifdef SWEEP_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif

  assign count_inc = count + ONE;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    limit_nxt = limit_q;
    unique case (state)
      IDLE: begin
        if (start_valid) begin
          limit_nxt = limit;
          count_nxt = '0;
          state_nxt = (limit == '0) ? DONE : UP;
        end
      end
      UP: begin
        if (abort) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else if (!stall) begin
          count_nxt = count_inc;
          if (count_inc == limit_q) state_nxt = (HOLD_CYCLES > 0) ? HOLD : DOWN;
        end
      end
      HOLD: begin
        if (abort) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else if (!stall && hold_last) begin
          state_nxt = DOWN;
        end
      end
      DOWN: begin
        if (abort) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else if (!stall) begin
          // Count 0 stays visible for one DOWN cycle before DONE.
          if (count == '0) state_nxt = DONE;
          else             count_nxt = count - ONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      count   <= '0;
      limit_q <= '0;
      dir     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      limit_q <= limit_nxt;
      dir     <= (state_nxt == UP);
      busy    <= (state_nxt != IDLE);
      done    <= (state_nxt == DONE);
    end
  end

  assign start_ready = (state == IDLE);

  sweep_hold_timer #(
    .HOLD_W      (HOLD_W),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_nxt != HOLD),
    .en   ((state == HOLD) && !stall),
    .last (hold_last)
  );
endmodule

// File: tb/tb_sweep_sequencer.sv
// Bench for sweep_sequencer: two instances (dwell 2 and dwell 0) share stimulus
// and are checked every cycle against a trajectory model of the sweep.
module tb_sweep_sequencer;
  localparam int W      = 8;
  localparam int HOLD_A = 2;
  localparam int HOLD_B = 0;
`ifdef SWEEP_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start_valid = 1'b0;
  logic         abort = 1'b0;
  logic         pause = 1'b0;
  logic [W-1:0] limit = '0;

  logic [W-1:0] cnt_o   [2];
  logic         ready_o [2];
  logic         dir_o   [2];
  logic         busy_o  [2];
  logic         done_o  [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Model: per instance, whether a sweep is in flight, cycles since acceptance, peak.
  bit act   [2];
  int k_m   [2];
  int lim_m [2];

  always #5 clk = ~clk;

  sweep_sequencer #(.WIDTH(W), .HOLD_CYCLES(HOLD_A), .HOLD_W(8)) dut_a (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(ready_o[0]),
    .limit(limit), .abort(abort),
`ifdef SWEEP_PAUSE_EN
    .pause(pause),
`endif
    .count(cnt_o[0]), .dir(dir_o[0]), .busy(busy_o[0]), .done(done_o[0])
  );

  sweep_sequencer #(.WIDTH(W), .HOLD_CYCLES(HOLD_B), .HOLD_W(8)) dut_b (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(ready_o[1]),
    .limit(limit), .abort(abort),
`ifdef SWEEP_PAUSE_EN
    .pause(pause),
`endif
    .count(cnt_o[1]), .dir(dir_o[1]), .busy(busy_o[1]), .done(done_o[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int hold_of(input int i);
    return (i == 0) ? HOLD_A : HOLD_B;
  endfunction

  // {ready, busy, dir, done, count} as a function of position in the sweep.
  function automatic logic [11:0] expect_out(input bit a, input int k, input int l, input int h);
    if (!a)                       return {4'b1000, 8'd0};
    if (l == 0 || k == 2*l+h+1)   return {4'b0101, 8'd0};
    if (k < l)                    return {4'b0110, 8'(k)};
    if (k < l + h)                return {4'b0100, 8'(l)};
    return {4'b0100, 8'(2*l + h - k)};
  endfunction

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int h;
      h = hold_of(i);
      if (!act[i]) begin
        if (start_valid) begin
          act[i]   = 1'b1;
          k_m[i]   = 0;
          lim_m[i] = int'(limit);
        end
      end else if (lim_m[i] == 0 || k_m[i] == 2*lim_m[i] + h + 1) begin
        act[i] = 1'b0;
      end else if (abort) begin
        act[i] = 1'b0;
      end else if (!pause) begin
        k_m[i]++;
      end
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      logic [11:0] e;
      e = expect_out(act[i], k_m[i], lim_m[i], hold_of(i));
      check($sformatf("count%0d", i), 32'(cnt_o[i]),  32'(e[7:0]));
      check($sformatf("done%0d", i),  32'(done_o[i]), 32'(e[8]));
      check($sformatf("dir%0d", i),   32'(dir_o[i]),  32'(e[9]));
      check($sformatf("busy%0d", i),  32'(busy_o[i]), 32'(e[10]));
      check($sformatf("ready%0d", i), 32'(ready_o[i]), 32'(e[11]));
    end
  endtask

  task automatic cycle(input logic sv, input logic [W-1:0] lim, input logic ab, input logic pz);
    start_valid = sv;
    limit       = lim;
    abort       = ab;
    pause       = pz & PAUSE_EN;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic go_idle();
    for (int n = 0; n < 4; n++) begin
      if (!act[0] && !act[1]) break;
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Accepts one sweep on the first call and reports cycles from acceptance to done.
  task automatic run_sweep(input int lim, input bit hold_sv, input int pz_at, input int pz_len,
                           output int lat0, output int lat1);
    int lat [2];
    lat[0] = -1;
    lat[1] = -1;
    for (int n = 1; n <= 700; n++) begin
      bit pz;
      pz = (n >= pz_at) && (n < pz_at + pz_len);
      cycle(hold_sv || (n == 1), W'(lim), 1'b0, pz);
      for (int i = 0; i < 2; i++)
        if (lat[i] < 0 && done_o[i] === 1'b1) lat[i] = n - 1;
      if (lat[0] >= 0 && lat[1] >= 0) break;
    end
    lat0 = lat[0];
    lat1 = lat[1];
  endtask

  function automatic int exp_lat(input int lim, input int h, input int pz);
    return (lim == 0) ? 0 : 2*lim + h + 1 + pz;
  endfunction

  initial begin
    int la, lb;
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0);

    run_sweep(3, 1'b0, 0, 0, la, lb);
    check("lat_l3_h2", la, exp_lat(3, HOLD_A, 0));
    check("lat_l3_h0", lb, exp_lat(3, HOLD_B, 0));
    go_idle();

    run_sweep(0, 1'b0, 0, 0, la, lb);
    check("lat_l0_a", la, 0);
    check("lat_l0_b", lb, 0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    run_sweep(2, 1'b0, 0, 0, la, lb);
    check("lat_l2_h0", lb, exp_lat(2, HOLD_B, 0));
    go_idle();

    // Asynchronous reset while counting up at 2.
    cycle(1'b1, 8'd5, 1'b0, 1'b0);
    cycle(1'b0, 8'd5, 1'b0, 1'b0);
    cycle(1'b0, 8'd5, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_count%0d", i), 32'(cnt_o[i]), 0);
      check($sformatf("rst_busy%0d", i),  32'(busy_o[i]), 0);
      check($sformatf("rst_ready%0d", i), 32'(ready_o[i]), 1);
      check($sformatf("rst_done%0d", i),  32'(done_o[i]), 0);
    end
    act[0] = 1'b0;
    act[1] = 1'b0;
    #1 rst = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Abort during the dwell of the HOLD_A instance.
    cycle(1'b1, 8'd3, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 8'd3, 1'b0, 1'b0);
    cycle(1'b0, 8'd3, 1'b1, 1'b0);
    cycle(1'b0, 8'd3, 1'b0, 1'b0);
    go_idle();

    // Abort while the HOLD_A instance sits in DONE: pulse must still complete.
    cycle(1'b1, 8'd3, 1'b0, 1'b0);
    repeat (9) cycle(1'b0, 8'd3, 1'b0, 1'b0);
    check("done_before_abort", 32'(done_o[0]), 1);
    cycle(1'b0, 8'd3, 1'b1, 1'b0);
    cycle(1'b0, 8'd3, 1'b0, 1'b0);
    go_idle();

    // Full-scale peak with start held high: second sweep only after DONE.
    run_sweep(255, 1'b1, 0, 0, la, lb);
    check("lat_l255_h2", la, exp_lat(255, HOLD_A, 0));
    check("lat_l255_h0", lb, exp_lat(255, HOLD_B, 0));
    cycle(1'b1, 8'd255, 1'b0, 1'b0);
    cycle(1'b1, 8'd255, 1'b0, 1'b0);
    go_idle();

    if (PAUSE_EN) begin
      // Pause for 3 cycles while the HOLD_A instance counts down at 5.
      run_sweep(8, 1'b0, 15, 3, la, lb);
      check("lat_pause_h2", la, exp_lat(8, HOLD_A, 3));
      check("lat_pause_h0", lb, exp_lat(8, HOLD_B, 3));
      go_idle();
    end

    for (int n = 0; n < 3000; n++) begin
      logic [W-1:0] l;
      l = ($urandom_range(0, 19) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 9));
      cycle($urandom_range(0, 2) == 0, l, $urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
